// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative shift-and-add multiplier for MULT/MULTU. One WIDTH-bit
//               add per CALC cycle, with its carry-out shifted into the
//               partial product. Signed operands are converted to magnitudes
//               at start and the product is negated once at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   C_ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] C_ONE_P    = (2*WIDTH)'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   low_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               neg_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] prod_d;

    // Operand magnitudes, the per-cycle add with carry-out, and the sign fix-up.
    // The most-negative value negates to itself, which read unsigned is the
    // correct magnitude 2^(WIDTH-1).
    always_comb begin
        a_mag_d = (is_signed && a[WIDTH-1]) ? ((~a) + C_ONE_W) : a;
        b_mag_d = (is_signed && b[WIDTH-1]) ? ((~b) + C_ONE_W) : b;
        neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        sum_d   = low_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        prod_d  = neg_q ? ((~{acc_q, low_q}) + C_ONE_P) : {acc_q, low_q};
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Capture everything now so later operand changes are harmless.
                        mcand_q <= a_mag_d;
                        low_q   <= b_mag_d;
                        neg_q   <= neg_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    // Shift {carry, acc, low} right by one.
                    acc_q   <= sum_d[WIDTH:1];
                    low_q   <= {sum_d[0], low_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + C_CNT_ONE;
                    if (cnt_q == C_CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                    lo_q    <= prod_d[WIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Directed self-checking bench for seq_multiplier, with a
//               64-bit instance and an 8-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start64 = 1'b0;
    logic        sg64 = 1'b0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        busy64, done64;
    logic [63:0] hi64, lo64;

    logic        start8 = 1'b0;
    logic        sg8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int n_checks = 0;
    int n_fail = 0;
    int n_overlap = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(64), .CNT_W(7)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .is_signed(sg64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .hi(hi64), .lo(lo64)
    );

    seq_multiplier #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sg8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    // busy and done must never be high together on either instance
    always @(negedge clk) begin
        if ((busy64 === 1'b1 && done64 === 1'b1) || (busy8 === 1'b1 && done8 === 1'b1))
            n_overlap++;
    end

    // Called at a negedge with the DUT idle; returns at the negedge where done
    // is seen (edges counted after the start edge) or after a 200-edge bound.
    task automatic run64(input logic [63:0] av, input logic [63:0] bv, input logic sg,
                         output int edges);
        a64 = av; b64 = bv; sg64 = sg; start64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start64 = 1'b0; a64 = ~av; b64 = bv ^ 64'h5A5A_5A5A; sg64 = ~sg;
        edges = 0;
        while (done64 !== 1'b1 && edges < 200) begin
            @(posedge clk); edges++; @(negedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sg,
                        output int edges);
        a8 = av; b8 = bv; sg8 = sg; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = bv ^ 8'h3C; sg8 = ~sg;
        edges = 0;
        while (done8 !== 1'b1 && edges < 40) begin
            @(posedge clk); edges++; @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy64, done64, hi64, lo64} !== {2'b00, 128'h0}) begin
            n_fail++;
            $display("FAIL reset64: busy=%b done=%b hi=%h lo=%h required all zero", busy64, done64, hi64, lo64);
        end
        n_checks++;
        if ({busy8, done8, hi8, lo8} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset8: busy=%b done=%b hi=%h lo=%h required all zero", busy8, done8, hi8, lo8);
        end
        rst = 1'b0;
        seen = 0;
        repeat (200) begin
            @(posedge clk); @(negedge clk);
            if (done64 !== 1'b0 || busy64 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, required 0", seen);
        end
    endtask

    task automatic test_multu();
        int e;
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, e);
        n_checks++;
        if (e !== 66) begin
            n_fail++;
            $display("FAIL multu_latency: %0d edges, required 66", e);
        end
        n_checks++;
        if (hi64 !== 64'hFFFF_FFFF_FFFF_FFFE || lo64 !== 64'h1) begin
            n_fail++;
            $display("FAIL multu_max: hi=%h lo=%h required hi=fffffffffffffffe lo=1", hi64, lo64);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (done64 !== 1'b0 || busy64 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b a cycle later, required 0 0", done64, busy64);
        end
        run64(64'h8000_0000_0000_0000, 64'h2, 1'b0, e);
        n_checks++;
        if (hi64 !== 64'h1 || lo64 !== 64'h0) begin
            n_fail++;
            $display("FAIL multu_msb: hi=%h lo=%h required hi=1 lo=0", hi64, lo64);
        end
    endtask

    task automatic test_mult_signed();
        int e;
        run64(64'hFFFF_FFFF_FFFF_FFFD, 64'h7, 1'b1, e);
        n_checks++;
        if (hi64 !== 64'hFFFF_FFFF_FFFF_FFFF || lo64 !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_neg3x7: hi=%h lo=%h required all-ones / ffffffffffffffeb", hi64, lo64);
        end
        run64(64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, e);
        n_checks++;
        if (hi64 !== 64'h0 || lo64 !== 64'd30) begin
            n_fail++;
            $display("FAIL mult_neg5xneg6: hi=%h lo=%h required 0 / 1e", hi64, lo64);
        end
        run64(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, e);
        n_checks++;
        if (e !== 66 || hi64 !== 64'h0 || lo64 !== 64'h8000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL mult_minxneg1: edges=%0d hi=%h lo=%h required 66 / 0 / 8000000000000000", e, hi64, lo64);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        a64 = 64'd5; b64 = 64'd6; sg64 = 1'b0; start64 = 1'b1;
        @(posedge clk); @(negedge clk);
        a64 = 64'd7; b64 = 64'd7;   // start stays high while busy and must be ignored
        e = 0;
        while (done64 !== 1'b1 && e < 200) begin
            @(posedge clk); e++; @(negedge clk);
        end
        n_checks++;
        if (e !== 66 || hi64 !== 64'h0 || lo64 !== 64'd30) begin
            n_fail++;
            $display("FAIL b2b_first: edges=%0d hi=%h lo=%h required 66 / 0 / 1e", e, hi64, lo64);
        end
        // new request in the done cycle
        a64 = 64'd0; b64 = 64'd12345; start64 = 1'b1;
        @(posedge clk); @(negedge clk);
        start64 = 1'b0; a64 = 64'hDEAD; b64 = 64'hBEEF;
        n_checks++;
        if (busy64 !== 1'b1 || lo64 !== 64'd30) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b lo=%h required busy=1 lo held at 1e", busy64, lo64);
        end
        e = 0;
        while (done64 !== 1'b1 && e < 200) begin
            @(posedge clk); e++; @(negedge clk);
        end
        n_checks++;
        if (e !== 66 || hi64 !== 64'h0 || lo64 !== 64'h0) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d hi=%h lo=%h required 66 / 0 / 0", e, hi64, lo64);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int seen;
        run64(64'd3, 64'd5, 1'b0, e);
        n_checks++;
        if (lo64 !== 64'd15) begin
            n_fail++;
            $display("FAIL pre_reset_op: lo=%h required f", lo64);
        end
        a64 = 64'd9; b64 = 64'd9; sg64 = 1'b0; start64 = 1'b1;
        @(posedge clk); @(negedge clk);
        start64 = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy64 !== 1'b0 || done64 !== 1'b0 || hi64 !== 64'h0 || lo64 !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required all zero", busy64, done64, hi64, lo64);
        end
        seen = 0;
        repeat (80) begin
            @(posedge clk); @(negedge clk);
            if (done64 !== 1'b0 || busy64 !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: %0d active cycles after abort, required 0", seen);
        end
        run64(64'd9, 64'd9, 1'b0, e);
        n_checks++;
        if (e !== 66 || hi64 !== 64'h0 || lo64 !== 64'd81) begin
            n_fail++;
            $display("FAIL after_reset: edges=%0d hi=%h lo=%h required 66 / 0 / 51", e, hi64, lo64);
        end
    endtask

    task automatic test_width8();
        int e;
        logic [7:0]  av, bv;
        logic signed [15:0] sa, sb;
        logic [15:0] exp_p;
        run8(8'hFF, 8'hFF, 1'b0, e);
        n_checks++;
        if (e !== 10 || {hi8, lo8} !== 16'hFE01) begin
            n_fail++;
            $display("FAIL w8_multu_ff: edges=%0d prod=%h required 10 / fe01", e, {hi8, lo8});
        end
        run8(8'h80, 8'h80, 1'b1, e);
        n_checks++;
        if (e !== 10 || {hi8, lo8} !== 16'h4000) begin
            n_fail++;
            $display("FAIL w8_mult_min: edges=%0d prod=%h required 10 / 4000", e, {hi8, lo8});
        end
        run8(8'h80, 8'hFF, 1'b1, e);
        n_checks++;
        if ({hi8, lo8} !== 16'h0080) begin
            n_fail++;
            $display("FAIL w8_mult_minxneg1: prod=%h required 0080", {hi8, lo8});
        end
        run8(8'h00, 8'h9C, 1'b1, e);
        n_checks++;
        if ({hi8, lo8} !== 16'h0000) begin
            n_fail++;
            $display("FAIL w8_zero_neg: prod=%h required 0000", {hi8, lo8});
        end
        for (int i = 0; i < 800; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            sa = {{8{av[7]}}, av};
            sb = {{8{bv[7]}}, bv};
            exp_p = (i % 2 == 1) ? 16'(sa * sb) : 16'({8'h00, av} * {8'h00, bv});
            run8(av, bv, 1'((i % 2) == 1), e);
            n_checks++;
            if (e !== 10 || {hi8, lo8} !== exp_p) begin
                n_fail++;
                $display("FAIL w8_sweep: a=%h b=%h signed=%0d edges=%0d prod=%h required %h",
                         av, bv, i % 2, e, {hi8, lo8}, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_signed();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        n_checks++;
        if (n_overlap !== 0) begin
            n_fail++;
            $display("FAIL busy_done_overlap: %0d cycles, required 0", n_overlap);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
